// File: rtl/uart_receiver.sv
// ============================================================================
// Module   : uart_receiver
// Purpose  : Serial-to-parallel UART receiver (8 data bits, LSB first, one
//            stop bit). Two-flop synchroniser on rx_i, start bit validated at
//            mid-bit, data and stop bits sampled at mid-bit. Each good frame
//            is presented on data with a one-cycle valid pulse.
// Params   : IN_FREQ / OUT_FREQ -> bit period DIV = IN_FREQ/OUT_FREQ clocks
//            (4 <= DIV <= 65535).
// Macro    : UART_RX_PARITY_EN - when defined, an even-parity bit follows the
//            data bits and parity_err is functional; otherwise parity_err = 0.
// Ports    : clk        - clock, rising edge
//            reset      - asynchronous, active-high reset
//            rx_i       - serial line, idle high, asynchronous to clk
//            data       - last correctly received byte
//            valid      - one-cycle pulse when data is updated
//            busy       - high while a frame is being received
//            frame_err  - one-cycle pulse when the stop bit is sampled low
//            parity_err - one-cycle pulse on a parity mismatch
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_receiver #(
  parameter int IN_FREQ  = 220052,
  parameter int OUT_FREQ = 96
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_i,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int          DIV_INT = IN_FREQ / OUT_FREQ;
  localparam logic [15:0] DIV     = DIV_INT[15:0];
  localparam logic [15:0] HALF    = DIV >> 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic        sync1_q, sync2_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q,   cnt_d;
  logic [2:0]  idx_q,   idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q,  data_d;
  logic        valid_q, valid_d;
  logic        busy_q,  busy_d;
  logic        ferr_q,  ferr_d;
  logic        w_rx_s;
  logic        w_expire;
  logic        w_par_bad;

`ifdef UART_RX_PARITY_EN
  logic        perr_q,  perr_d;
  logic        pbad_q,  pbad_d;   // parity result held from PARITY until STOP
  assign w_par_bad  = pbad_q;
  assign parity_err = perr_q;
`else
  assign w_par_bad  = 1'b0;
  assign parity_err = 1'b0;
`endif

  assign w_rx_s    = sync2_q;
  // The counter is loaded with N on entry; the sample happens N edges later.
  assign w_expire  = (cnt_q == 16'd1);

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign frame_err = ferr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d  = 1'b0;
    pbad_d  = pbad_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!w_rx_s) begin
          cnt_d   = HALF;
          busy_d  = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        if (w_expire) begin
          if (!w_rx_s) begin
            cnt_d   = DIV;
            idx_d   = 3'd0;
            state_d = S_DATA;
          end else begin
            // Line went back high before mid-bit: treat as a glitch.
            cnt_d   = 16'd0;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (w_expire) begin
          shreg_d[idx_q] = w_rx_s;
          cnt_d          = DIV;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_expire) begin
          // Even parity: the parity bit equals the XOR of the data bits.
          pbad_d  = w_rx_s ^ (^shreg_q);
          cnt_d   = DIV;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (w_expire) begin
          cnt_d = 16'd0;
          if (w_rx_s) begin
            if (w_par_bad) begin
`ifdef UART_RX_PARITY_EN
              perr_d = 1'b1;
`endif
            end else begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_BREAK: begin
        // Hold off until the line returns high so a stuck-low line is not
        // decoded as a stream of 0x00 frames.
        if (w_rx_s) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        cnt_d   = 16'd0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      shreg_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
      pbad_q  <= 1'b0;
`endif
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      perr_q  <= perr_d;
      pbad_q  <= pbad_d;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// Module   : tb_uart_receiver
// Purpose  : Self-checking bench for uart_receiver (IN_FREQ=20, OUT_FREQ=1,
//            DIV=20). A frame-level reference model predicts every valid,
//            frame_err and parity_err pulse (edge number and byte) and the
//            busy rise/fall edges for directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_receiver;

  localparam int DIV = 20;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Edge of the stop-bit sample relative to the edge that first captures start.
  localparam int STOP_OFS = 2 + DIV / 2 + (NBITS - 1) * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_i = 1'b1;
  logic [7:0] data;
  logic       valid, busy, frame_err, parity_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int         obs_vc[$];
  logic [7:0] obs_vd[$];
  int         obs_fe[$];
  int         obs_pe[$];
  int         exp_vc[$];
  logic [7:0] exp_vd[$];
  int         exp_fe[$];
  int         exp_pe[$];
  int         rise_q[$];
  int         fall_q[$];
  logic       busy_prev = 1'b0;
  logic [7:0] model_data = 8'h00;

  uart_receiver #(.IN_FREQ(20), .OUT_FREQ(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_i       (rx_i),
    .data       (data),
    .valid      (valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs registered at edge N are observed at the negedge where cyc == N.
  always @(negedge clk) begin
    if (valid)      begin obs_vc.push_back(cyc); obs_vd.push_back(data); end
    if (frame_err)  obs_fe.push_back(cyc);
    if (parity_err) obs_pe.push_back(cyc);
    if (busy && !busy_prev) rise_q.push_back(cyc);
    if (!busy && busy_prev) fall_q.push_back(cyc);
    busy_prev <= busy;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx_i = b;
    repeat (n) @(negedge clk);
  endtask

  // Sends one frame and records the model's prediction; returns the start edge.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int gap, output int s);
    logic good_par;
    s = cyc + 1;
    drive_bit(1'b0, DIV);
    for (int k = 0; k < 8; k++) drive_bit(b[k], DIV);
`ifdef UART_RX_PARITY_EN
    drive_bit(par, DIV);
    good_par = (par == ^b);
`else
    good_par = 1'b1;
`endif
    drive_bit(stop, DIV);
    if (!stop) exp_fe.push_back(s + STOP_OFS);
    else if (!good_par) exp_pe.push_back(s + STOP_OFS);
    else begin
      exp_vc.push_back(s + STOP_OFS);
      exp_vd.push_back(b);
      model_data = b;
    end
    drive_bit(1'b1, gap);
  endtask

  task automatic compare_events(input string tag);
    drive_bit(1'b1, 4);
    check({tag, "_nvalid"}, obs_vc.size(), exp_vc.size());
    for (int i = 0; i < obs_vc.size() && i < exp_vc.size(); i++) begin
      check({tag, "_valid_edge"}, obs_vc[i], exp_vc[i]);
      check({tag, "_valid_data"}, {24'd0, obs_vd[i]}, {24'd0, exp_vd[i]});
    end
    check({tag, "_nferr"}, obs_fe.size(), exp_fe.size());
    for (int i = 0; i < obs_fe.size() && i < exp_fe.size(); i++)
      check({tag, "_ferr_edge"}, obs_fe[i], exp_fe[i]);
    check({tag, "_nperr"}, obs_pe.size(), exp_pe.size());
    for (int i = 0; i < obs_pe.size() && i < exp_pe.size(); i++)
      check({tag, "_perr_edge"}, obs_pe[i], exp_pe[i]);
    check({tag, "_data_hold"}, {24'd0, data}, {24'd0, model_data});
    obs_vc.delete(); obs_vd.delete(); obs_fe.delete(); obs_pe.delete();
    exp_vc.delete(); exp_vd.delete(); exp_fe.delete(); exp_pe.delete();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_data"},  {24'd0, data}, 32'd0);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy}, 32'd0);
    check({tag, "_ferr"},  {31'd0, frame_err}, 32'd0);
    check({tag, "_perr"},  {31'd0, parity_err}, 32'd0);
  endtask

  initial begin
    int s, s2, r;
    logic [7:0] b;
    logic stop, par;
    int gap;

    // Reset state
    @(negedge clk);
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    drive_bit(1'b1, 10);
    rise_q.delete(); fall_q.delete();

    // Glitch: 5 low cycles, start check at edge 12 sees high
    s = cyc + 1;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 30);
    check("glitch_nrise", rise_q.size(), 1);
    check("glitch_rise", rise_q.size() > 0 ? rise_q[0] : -1, s + 2);
    check("glitch_fall", fall_q.size() > 0 ? fall_q[0] : -1, s + 12);
    compare_events("glitch");
    rise_q.delete(); fall_q.delete();

    // Good frame 0x8E
    send_frame(8'h8E, ^8'h8E, 1'b1, 10, s);
    check("good_rise", rise_q.size() > 0 ? rise_q[0] : -1, s + 2);
    check("good_fall", fall_q.size() > 0 ? fall_q[0] : -1, s + STOP_OFS);
    compare_events("good");
    rise_q.delete(); fall_q.delete();

    // Framing error 0x3C: stop low, held low a further 50 cycles
    send_frame(8'h3C, ^8'h3C, 1'b0, 0, s);
    drive_bit(1'b0, 50);
    r = cyc + 1;
    drive_bit(1'b1, 30);
    check("ferr_nfall", fall_q.size(), 1);
    check("ferr_fall", fall_q.size() > 0 ? fall_q[0] : -1, r + 2);
    compare_events("ferr");
    rise_q.delete(); fall_q.delete();

    // Back-to-back 0x55, 0xAA
    send_frame(8'h55, ^8'h55, 1'b1, 0, s);
    send_frame(8'hAA, ^8'hAA, 1'b1, 10, s2);
    check("b2b_start_spacing_model", s2 - s, NBITS * DIV);
    if (obs_vc.size() >= 2) check("b2b_spacing", obs_vc[1] - obs_vc[0], NBITS * DIV);
    else                    check("b2b_count", obs_vc.size(), 2);
    compare_events("b2b");

    // Randomised frames, random gaps, occasional bad stop / parity bits
    for (int i = 0; i < 12; i++) begin
      b    = 8'($urandom);
      stop = ($urandom % 6) != 0;
      par  = (($urandom % 4) == 0) ? ~(^b) : ^b;
      gap  = stop ? int'($urandom_range(0, 25)) : int'($urandom_range(5, 25));
      send_frame(b, par, stop, gap, s);
    end
    compare_events("rand");

    // Reset during data bit 4, then a clean 0x81
    drive_bit(1'b0, DIV);
    b = 8'h81;
    for (int k = 0; k < 4; k++) drive_bit(b[k], DIV);
    drive_bit(b[4], DIV / 2);
    reset = 1'b1;
    @(negedge clk);
    check_outputs_zero("midrst");
    model_data = 8'h00;
    drive_bit(1'b1, 3);
    reset = 1'b0;
    drive_bit(1'b1, 30);
    send_frame(8'h81, ^8'h81, 1'b1, 10, s);
    compare_events("midrst");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 20, s);
    send_frame(8'h07, 1'b0, 1'b1, 20, s);
    compare_events("parity");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver that pairs with the team's `uart_transmitter` and shares its `IN_FREQ`/`OUT_FREQ` bit-rate convention. It synchronises the asynchronous `rx` line and validates the start bit at mid-bit. It then samples 8 data bits LSB-first at mid-bit and checks the stop bit. Each good frame is presented on `data` with a one-cycle `valid` pulse. It sits between the board `rx` pin and the character-consuming logic in the top-level task modules.

## Interface
- `IN_FREQ`, default 220052: input clock rate, in the same units as `OUT_FREQ`.
- `OUT_FREQ`, default 96: line bit rate. Bit period `DIV = IN_FREQ/OUT_FREQ` clk cycles (integer division). Legal range is 4 ≤ DIV ≤ 65535; the counters are 16 bits wide.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: reset is asynchronous and active-high.
- `rx_i` input 1: serial line, idle high, asynchronous to `clk`.
- `data` output 8: last correctly received byte.
- `valid` output 1: one-cycle pulse when `data` is updated.
- `busy` output 1: high while a frame is being received.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `parity_err` output 1: one-cycle pulse on a parity mismatch. Always 0 unless `UART_RX_PARITY_EN` is defined.

## Operation
- **Synchronizer:** two flops, `rx_s` is the synchronised line. Both flops reset to 1.
- **Reset values:** `data`=0x00, `valid`=0, `busy`=0, `frame_err`=0, `parity_err`=0, state IDLE, counters 0.
- **IDLE:** on `rx_s`==0, load the counter with DIV/2 (floor), set `busy`, and go to START.
- **START:** when the counter expires, resample `rx_s`.
  - Low: load DIV and go to DATA with bit index 0.
  - High (glitch): clear `busy` and return to IDLE. No pulse is emitted.
- **DATA:** every DIV cycles, shift `rx_s` into bit [index] of the shift register (LSB first). After bit 7, go to PARITY if enabled, otherwise to STOP.
- **PARITY** (macro only): sample one bit; the expected value is even parity over the 8 data bits. Then go to STOP.
- **STOP:** sample at mid-bit.
  - High, parity OK: copy the shift register to `data`, pulse `valid`, clear `busy`, go to IDLE. A new start edge is accepted from the next cycle (during the second half of the stop bit).
  - High, parity bad: pulse `parity_err`; `data` is unchanged and there is no `valid`. Clear `busy` and go to IDLE.
  - Low: pulse `frame_err`; `data` is unchanged and there is no `valid`. Go to BREAK.
- **BREAK:** keep `busy`=1 until `rx_s`==1, then clear `busy` and go to IDLE. This prevents a held-low line from being decoded as repeated 0x00 frames.
- **No consumer handshake:** `valid` is a pulse. `data` holds until the next good frame; overrun is not flagged.
- **Reset mid-frame:** return to IDLE immediately with all outputs at their reset values. The partial frame is discarded.

## Timing
- **Start detection:** let cycle 0 be the first rising edge that captures `rx_i`=0 in sync flop 1. `rx_s` goes low after edge 1, and IDLE→START happens at edge 2.
- **Bit sampling points:**
  - Start-bit check at edge 2+DIV/2.
  - Data bit k at edge 2+DIV/2+(k+1)·DIV.
  - Stop bit at edge 2+DIV/2+9·DIV (add DIV with parity).
- **Stop-bit outputs:** `valid`, `data`, `frame_err` and `parity_err` are registered at the stop-sample edge and are high for exactly one cycle after it. `busy` falls on that same edge, except in the BREAK case.
- **`busy` rise:** `busy` rises at edge 2.
- **Back-to-back frames:** frames with no idle gap are received without loss. Consecutive `valid` pulses are 10·DIV cycles apart (11·DIV with parity).

## Configuration
- **`UART_RX_PARITY_EN`:**
  - Defined: frame is start + 8 data + even parity + stop (11 bits), and `parity_err` is functional.
  - Undefined: frame is 10 bits, no PARITY state, and `parity_err` is tied to 0.
- The port list is identical in both builds.

## Test plan
All scenarios use IN_FREQ=20, OUT_FREQ=1 (DIV=20), macro undefined unless stated.
- **Good frame:** send 0x8E (idle, start, 0,1,1,1,0,0,0,1, stop) → `data`=0x8E with one `valid` pulse at edge 2+10+180 after the start edge. `frame_err`=0. `busy` is high from edge 2 until the stop sample.
- **Glitch:** drive `rx_i` low for 5 cycles, then high → no `valid`, no `frame_err`. `busy` pulses and returns to 0 at edge 12. `data` stays 0x00.
- **Framing error:** send 0x3C with the stop bit low, hold low 50 cycles, then release → `frame_err` pulse, no `valid`, `data` unchanged. `busy` stays high until `rx_s` returns high.
- **Back-to-back:** send 0x55 then 0xAA with no idle gap → two `valid` pulses 200 cycles apart, carrying 0x55 then 0xAA.
- **Reset mid-frame:** assert `reset` during data bit 4, release, then send 0x81 → all outputs 0 during reset, no pulse for the aborted frame, then `data`=0x81 with `valid`.
- **Parity (macro defined):** send 0x07 with parity bit 1 → `valid`, `data`=0x07. Resend with parity bit 0 → `parity_err` pulse, no `valid`, `data` stays 0x07.
